// File: rtl/monocycle_pkg.sv
// Shared encodings for the monocycle core's data-memory stage.
package monocycle_pkg;

  // Funct3 access types; the encodings not listed here are handled as word accesses
  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dmctrl_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RDWAIT = 1'b1
  } dmem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } dm_size_t;

  function automatic dm_size_t dm_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_B, DM_BU: return SZ_B;
      DM_H, DM_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic dm_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
    case (dm_size(ctrl))
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  // Only B and H sign-extend; bit 2 set marks the unsigned variants
  function automatic logic dm_signed(input logic [2:0] ctrl);
    return !ctrl[2];
  endfunction

endpackage

// File: rtl/dmem_unit_if.sv
// Core-to-data-memory bus of the monocycle pipeline.
interface dmem_unit_if;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic        DMRd;
  logic [2:0]  DMCtrl;
  logic [31:0] DataRd;
  logic        Stall;
  logic        Misaligned;

  modport master (
    output Address, DataWr, DMWr, DMRd, DMCtrl,
    input  DataRd, Stall, Misaligned
  );

  modport slave (
    input  Address, DataWr, DMWr, DMRd, DMCtrl,
    output DataRd, Stall, Misaligned
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and registered read data.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           re,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes and synchronous read; contents are never reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: alignment check, store lane enables, two-cycle loads with extension.
module dmem_unit
  import monocycle_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  dmem_unit_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_t state, state_n;
  logic [2:0]  lat_ctrl;
  logic [1:0]  lat_lane;
  logic        mis, access_ok, rd_go, wr_go;
  logic [3:0]  we;
  logic [31:0] wdata, rdata, ext;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [AW-1:0] widx;

  // Higher address bits are dropped so the RAM aliases across the address space
  assign widx = bus.Address[AW+1:2];

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .re    (rd_go),
    .we    (we),
    .addr  (widx),
    .wdata (wdata),
    .rdata (rdata)
  );

  // State register plus access type and lane captured when a load is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_ctrl <= '0;
      lat_lane <= '0;
    end else begin
      state <= state_n;
      if (rd_go) begin
        lat_ctrl <= bus.DMCtrl;
        lat_lane <= bus.Address[1:0];
      end
    end
  end

  // Access qualification, next state, Stall and Misaligned
  always_comb begin
    mis       = dm_misaligned(bus.DMCtrl, bus.Address[1:0]);
    access_ok = (state == IDLE) && !rst;
    // A simultaneous store request is dropped in favour of the load
    rd_go     = access_ok && bus.DMRd && !mis;
    wr_go     = access_ok && bus.DMWr && !bus.DMRd && !mis;
    state_n   = state;
    case (state)
      IDLE:    if (rd_go) state_n = RDWAIT;
      RDWAIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    bus.Stall      = rd_go;
    bus.Misaligned = access_ok && (bus.DMRd || bus.DMWr) && mis;
  end

  // Store lane enables and lane-replicated write data
  always_comb begin
    we    = '0;
    wdata = bus.DataWr;
    case (dm_size(bus.DMCtrl))
      SZ_B: begin
        we    = 4'b0001 << bus.Address[1:0];
        wdata = {4{bus.DataWr[7:0]}};
      end
      SZ_H: begin
        we    = bus.Address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.DataWr[15:0]}};
      end
      default: we = 4'b1111;
    endcase
    if (!wr_go) we = '0;
  end

  // Lane selection and sign/zero extension of the registered read word
  always_comb begin
    lane_byte = rdata[8*lat_lane +: 8];
    lane_half = lat_lane[1] ? rdata[31:16] : rdata[15:0];
    ext       = rdata;
    case (dm_size(lat_ctrl))
      SZ_B: ext = dm_signed(lat_ctrl) ? {{24{lane_byte[7]}}, lane_byte}
                                      : {24'b0, lane_byte};
      SZ_H: ext = dm_signed(lat_ctrl) ? {{16{lane_half[15]}}, lane_half}
                                      : {16'b0, lane_half};
      default: ext = rdata;
    endcase
    bus.DataRd = (state == RDWAIT && !rst) ? ext : '0;
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit against a byte-array memory model.
module tb_dmem_unit;
  import monocycle_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_unit_if dif();

  dmem_unit #(.DEPTH_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    logic        stall;
    logic        mis;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  byte unsigned m[4096];

  function automatic exp_t mk(input logic s, input logic mi, input logic [31:0] d, input string t);
    exp_t e;
    e.stall = s;
    e.mis   = mi;
    e.data  = d;
    e.tag   = t;
    return e;
  endfunction

  function automatic int unsigned acc_bytes(input logic [2:0] c);
    case (c)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] c, input logic [31:0] a);
    return (a % acc_bytes(c)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a);
    logic [63:0]  v;
    int unsigned  n, base;
    v    = '0;
    n    = acc_bytes(c);
    base = a % 4096;
    for (int unsigned i = 0; i < n; i++)
      v = v | (64'(m[(base + i) % 4096]) << (8 * i));
    if (n < 4 && c[2] == 1'b0 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    int unsigned n, base;
    n    = acc_bytes(c);
    base = a % 4096;
    for (int unsigned i = 0; i < n; i++) m[(base + i) % 4096] = 8'(d >> (8 * i));
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] d);
    dif.DMWr    = wr;
    dif.DMRd    = rd;
    dif.DMCtrl  = c;
    dif.Address = a;
    dif.DataWr  = d;
  endtask

  task automatic drive_junk();
    drive(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
  endtask

  // One bus request; a legal load also occupies the following cycle with junk inputs
  task automatic op(input bit wr, input bit rd, input logic [2:0] c,
                    input logic [31:0] a, input logic [31:0] d, input string tag,
                    input bit abort = 1'b0);
    bit          mi;
    logic [31:0] e;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(wr, rd, c, a, d);
    mi = (wr || rd) && ref_mis(c, a);
    if (rd && !mi) begin
      e = ref_load(c, a);
      q.push_back(mk(1'b1, 1'b0, 32'h0, {tag, "/stall"}));
      @(posedge clk); #1;
      drive_junk();
      if (abort) begin
        rst = 1'b1;
        q.push_back(mk(1'b0, 1'b0, 32'h0, {tag, "/abort"}));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        q.push_back(mk(1'b0, 1'b0, 32'h0, {tag, "/after"}));
      end else begin
        q.push_back(mk(1'b0, 1'b0, e, tag));
      end
    end else begin
      if (wr && !rd && !mi) ref_store(c, a, d);
      q.push_back(mk(1'b0, mi, 32'h0, tag));
    end
  endtask

  task automatic reset_cycle(input bit wr, input bit rd, input logic [2:0] c,
                             input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(wr, rd, c, a, d);
    q.push_back(mk(1'b0, 1'b0, 32'h0, "reset"));
  endtask

  // Monitor: compare every cycle that has an expectation queued
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (dif.Stall !== e.stall || dif.Misaligned !== e.mis || dif.DataRd !== e.data) begin
          errors++;
          $display("FAIL %s: got Stall=%0b Misaligned=%0b DataRd=%h, expected Stall=%0b Misaligned=%0b DataRd=%h",
                   e.tag, dif.Stall, dif.Misaligned, dif.DataRd, e.stall, e.mis, e.data);
        end
      end
    end
  end

  initial begin
    logic [2:0]  c;
    logic [31:0] a;
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) reset_cycle(1'b1, 1'($urandom), 3'd2, 32'h10, $urandom);

    for (int unsigned i = 0; i < 1024; i++) op(1'b1, 1'b0, DM_W, i * 4, $urandom, "fill");

    op(1'b1, 1'b0, DM_W,  32'h10, 32'hDEADBEEF, "sw");
    op(1'b0, 1'b1, DM_W,  32'h10, 32'h0, "lw");
    op(1'b1, 1'b0, DM_B,  32'h13, 32'h00000080, "sb");
    op(1'b0, 1'b1, DM_B,  32'h13, 32'h0, "lb");
    op(1'b0, 1'b1, DM_BU, 32'h13, 32'h0, "lbu");
    op(1'b0, 1'b1, DM_W,  32'h10, 32'h0, "lw_after_sb");
    op(1'b1, 1'b0, DM_H,  32'h12, 32'h00008001, "sh");
    op(1'b0, 1'b1, DM_H,  32'h12, 32'h0, "lh");
    op(1'b0, 1'b1, DM_HU, 32'h12, 32'h0, "lhu");
    op(1'b0, 1'b1, DM_W,  32'h10, 32'h0, "lw_after_sh");
    op(1'b0, 1'b1, DM_W,  32'h11, 32'h0, "lw_mis");
    op(1'b1, 1'b0, DM_H,  32'h13, 32'hFFFFFFFF, "sh_mis");
    op(1'b0, 1'b1, DM_W,  32'h10, 32'h0, "lw_after_mis");
    op(1'b0, 1'b1, DM_W,  32'h10, 32'h0, "lw_abort", 1'b1);
    op(1'b0, 1'b1, DM_W,  32'h10, 32'h0, "lw_after_abort");
    reset_cycle(1'b1, 1'b0, DM_W, 32'h10, 32'h0);
    op(1'b0, 1'b1, DM_W,  32'h10, 32'h0, "lw_after_rst_wr");
    op(1'b1, 1'b0, DM_W,  32'h1000, 32'h12345678, "sw_wrap");
    op(1'b0, 1'b1, DM_W,  32'h0, 32'h0, "lw_wrap");
    op(1'b1, 1'b1, DM_W,  32'h20, 32'hCAFEF00D, "rd_wr_both");
    op(1'b0, 1'b1, DM_W,  32'h20, 32'h0, "lw_after_both");
    op(1'b0, 1'b1, DM_W,  32'h20, 32'h0, "lw_b2b");

    for (int i = 0; i < 800; i++) begin
      c = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = {$urandom_range(0, 1) == 0 ? 20'h0 : a[31:12], 6'h0, a[5:0]};
      op(1'($urandom), 1'($urandom), c, a, $urandom, "rand");
    end

    op(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, "idle");
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
